isa_pnp_key_sender: RTL and testbench

//  Drives the ISA PnP Initiation Key onto the bus as I/O writes to port 0x279: LEAD_ZEROS writes of 0x00, then the KEY_LEN-byte LFSR key.
//  Bus-master side of the key protocol; drives bring-up self-test, card-side key-detector loopback and host-emulation benches.

---
 rtl/isa_pnp_key_sender.sv | 188 ++++++++++++++++++
 tb/tb_isa_pnp_key_sender.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_pnp_key_sender.sv
// ISA PnP Initiation Key sender: bus-master FSM issuing LEAD_ZEROS 0x00 writes, then the
// LFSR key, as I/O writes to PORT_ADDR. It drives the bus only while it holds the grant.
module isa_pnp_key_sender #(
    parameter logic [9:0]  PORT_ADDR   = 10'h279,
    parameter int unsigned KEY_LEN     = 32,
    parameter int unsigned LEAD_ZEROS  = 2,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned STROBE_CYC  = 8,
    parameter int unsigned RECOVER_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       inject_en,
    input  logic [4:0] inject_idx,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [9:0] isa_addr_o,
    output logic [7:0] isa_data_o,
    output logic       isa_data_oe,
    output logic       isa_iow_n_o,
    output logic       isa_aen_o,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [5:0] write_idx
);

    localparam logic [7:0] LfsrSeed    = 8'h6A;
    localparam logic [5:0] Lead        = 6'(LEAD_ZEROS);
    localparam logic [5:0] LastIdx     = 6'(LEAD_ZEROS + KEY_LEN - 1);
    localparam logic [7:0] SetupLast   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] StrobeLast  = 8'(STROBE_CYC - 1);
    localparam logic [7:0] RecoverLast = 8'(RECOVER_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StSetup,
        StStrobe,
        StRecover,
        StRelease
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  lfsr;
    logic        inj_en_q;
    logic [4:0]  inj_idx_q;
    logic        abort_q;

    logic        lose_bus;
    logic [5:0]  nxt_idx;
    logic [7:0]  nxt_lfsr;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[0] ^ v[1], v[7:1]};
    endfunction

    function automatic logic [7:0] pick_byte(input logic [5:0] idx, input logic [7:0] lf,
                                             input logic en, input logic [4:0] inj);
        if (idx < Lead) begin
            return 8'h00;
        end
        if (en && ((idx - Lead) == {1'b0, inj})) begin
            return ~lf;
        end
        return lf;
    endfunction

    // The isa_aen_o line stays low whether or not this master owns the bus.
    assign isa_aen_o = 1'b0;
    assign lose_bus  = abort | ~bus_gnt;
    assign nxt_idx   = write_idx + 6'd1;
    assign nxt_lfsr  = (write_idx >= Lead) ? lfsr_step(lfsr) : lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= 8'd0;
            lfsr        <= LfsrSeed;
            inj_en_q    <= 1'b0;
            inj_idx_q   <= 5'd0;
            abort_q     <= 1'b0;
            bus_req     <= 1'b0;
            isa_addr_o  <= 10'd0;
            isa_data_o  <= 8'd0;
            isa_data_oe <= 1'b0;
            isa_iow_n_o <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            write_idx   <= 6'd0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StReq;
                        bus_req   <= 1'b1;
                        busy      <= 1'b1;
                        inj_en_q  <= inject_en;
                        inj_idx_q <= inject_idx;
                        write_idx <= 6'd0;
                        lfsr      <= LfsrSeed;
                        abort_q   <= 1'b0;
                    end
                end
                StReq: begin
                    if (abort) begin
                        state   <= StIdle;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (bus_gnt) begin
                        state       <= StSetup;
                        cnt         <= 8'd0;
                        isa_data_oe <= 1'b1;
                        isa_addr_o  <= PORT_ADDR;
                        isa_data_o  <= pick_byte(write_idx, lfsr, inj_en_q, inj_idx_q);
                    end
                end
                StSetup: begin
                    if (lose_bus) begin
                        state   <= StRelease;
                        abort_q <= 1'b1;
                    end else if (cnt == SetupLast) begin
                        state       <= StStrobe;
                        cnt         <= 8'd0;
                        isa_iow_n_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StStrobe: begin
                    if (lose_bus) begin
                        state       <= StRelease;
                        abort_q     <= 1'b1;
                        isa_iow_n_o <= 1'b1;
                    end else if (cnt == StrobeLast) begin
                        state       <= StRecover;
                        cnt         <= 8'd0;
                        isa_iow_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StRecover: begin
                    if (lose_bus) begin
                        state   <= StRelease;
                        abort_q <= 1'b1;
                    end else if (cnt == RecoverLast) begin
                        cnt <= 8'd0;
                        if (write_idx == LastIdx) begin
                            state <= StRelease;
                        end else begin
                            // Data only changes here, with IOW# already high for RECOVER_CYC.
                            state      <= StSetup;
                            write_idx  <= nxt_idx;
                            lfsr       <= nxt_lfsr;
                            isa_data_o <= pick_byte(nxt_idx, nxt_lfsr, inj_en_q, inj_idx_q);
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StRelease: begin
                    state       <= StIdle;
                    isa_iow_n_o <= 1'b1;
                    isa_data_oe <= 1'b0;
                    isa_addr_o  <= 10'd0;
                    isa_data_o  <= 8'd0;
                    bus_req     <= 1'b0;
                    busy        <= 1'b0;
                    if (abort_q) begin
                        aborted <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_isa_pnp_key_sender.sv
// Directed self-checking bench for isa_pnp_key_sender: full sequence, injection, aborts,
// delayed grant, grant loss and asynchronous reset.
`timescale 1ns/1ps
module tb_isa_pnp_key_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       inject_en;
    logic [4:0] inject_idx;
    logic       bus_req;
    logic       bus_gnt;
    logic [9:0] isa_addr_o;
    logic [7:0] isa_data_o;
    logic       isa_data_oe;
    logic       isa_iow_n_o;
    logic       isa_aen_o;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [5:0] write_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] key [32] = '{
        8'h6A, 8'hB5, 8'hDA, 8'hED, 8'hF6, 8'hFB, 8'h7D, 8'hBE,
        8'hDF, 8'h6F, 8'h37, 8'h1B, 8'h0D, 8'h86, 8'hC3, 8'h61,
        8'hB0, 8'h58, 8'h2C, 8'h16, 8'h8B, 8'h45, 8'hA2, 8'hD1,
        8'hE8, 8'h74, 8'h3A, 8'h9D, 8'hCE, 8'hE7, 8'h73, 8'h39
    };

    isa_pnp_key_sender dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .inject_en  (inject_en),
        .inject_idx (inject_idx),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .isa_addr_o (isa_addr_o),
        .isa_data_o (isa_data_o),
        .isa_data_oe(isa_data_oe),
        .isa_iow_n_o(isa_iow_n_o),
        .isa_aen_o  (isa_aen_o),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .write_idx  (write_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] exp_byte(input int i);
        return (i < 2) ? 8'h00 : key[i-2];
    endfunction

    // Write monitor: records data/addr/low-width of each IOW# pulse, flags instability.
    logic       prev_iow = 1'b1;
    int         low_cnt  = 0;
    logic [7:0] low_data;
    logic [9:0] low_addr;
    int         glitch   = 0;
    logic [7:0] wr_data [$];
    logic [9:0] wr_addr [$];
    int         wr_width [$];

    always @(negedge clk) begin
        if (isa_iow_n_o === 1'b0) begin
            if (isa_data_oe !== 1'b1) glitch++;
            if (prev_iow) begin
                low_cnt  = 1;
                low_data = isa_data_o;
                low_addr = isa_addr_o;
            end else begin
                low_cnt++;
                if (isa_data_o !== low_data || isa_addr_o !== low_addr) glitch++;
            end
        end else if (!prev_iow) begin
            wr_data.push_back(low_data);
            wr_addr.push_back(low_addr);
            wr_width.push_back(low_cnt);
        end
        prev_iow = isa_iow_n_o;
    end

    task automatic clear_mon();
        wr_data.delete();
        wr_addr.delete();
        wr_width.delete();
        glitch = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        int n = 0;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        seen = (done === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; inject_en = 1'b0; inject_idx = 5'd0;
        bus_gnt = 1'b1;
        #12;
        n_checks++;
        if ({bus_req, isa_data_oe, isa_iow_n_o, isa_addr_o, isa_data_o, busy, done, aborted,
             write_idx, isa_aen_o} !== {1'b0, 1'b0, 1'b1, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0,
             6'd0, 1'b0})
            $display("FAIL reset_values: got req=%b oe=%b iow=%b addr=%h data=%h busy=%b idx=%0d",
                     bus_req, isa_data_oe, isa_iow_n_o, isa_addr_o, isa_data_o, busy, write_idx);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        // abort while idle does nothing
        abort = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, bus_req, aborted} !== 3'b000)
            $display("FAIL idle_abort_ignored: got busy/req/aborted=%b%b%b required 000",
                     busy, bus_req, aborted);
        else n_pass++;
        abort = 1'b0;
    endtask

    task automatic test_abort_req();
        bus_gnt = 1'b0;
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++;
        if ({busy, bus_req} !== 2'b11)
            $display("FAIL start_beats_abort: got busy/req=%b%b required 11", busy, bus_req);
        else n_pass++;
        @(negedge clk); abort = 1'b0;
        n_checks++;
        if ({aborted, bus_req, busy} !== 3'b100)
            $display("FAIL abort_in_req: got aborted/req/busy=%b%b%b required 100",
                     aborted, bus_req, busy);
        else n_pass++;
        bus_gnt = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_sequence();
        int t0, t1, n;
        bit seen;
        clear_mon();
        pulse_start();
        n = 0;
        while (isa_data_oe !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        t0 = cyc;
        wait_done(seen);
        t1 = cyc;
        n_checks++;
        if (!seen || (t1 - t0) !== 477)
            $display("FAIL full_latency: got seen=%0d cycles=%0d required 477", seen, t1 - t0);
        else n_pass++;
        n_checks++;
        if (wr_data.size() !== 34)
            $display("FAIL full_count: got %0d writes required 34", wr_data.size());
        else n_pass++;
        for (int i = 0; i < 34 && i < wr_data.size(); i++) begin
            n_checks++;
            if (wr_data[i] !== exp_byte(i) || wr_addr[i] !== 10'h279 || wr_width[i] !== 8)
                $display("FAIL full_write%0d: got data=%h addr=%h width=%0d required %h 279 8",
                         i, wr_data[i], wr_addr[i], wr_width[i], exp_byte(i));
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({glitch != 0, busy, isa_data_oe, bus_req, isa_iow_n_o, done} !== 6'b000010)
            $display("FAIL full_post: got glitch=%0d busy=%b oe=%b req=%b iow=%b done=%b",
                     glitch, busy, isa_data_oe, bus_req, isa_iow_n_o, done);
        else n_pass++;
    endtask

    task automatic test_inject();
        bit seen;
        clear_mon();
        inject_en = 1'b1; inject_idx = 5'd5;
        pulse_start();
        inject_en = 1'b0; inject_idx = 5'd0;
        wait_done(seen);
        n_checks++;
        if (!seen || wr_data.size() !== 34)
            $display("FAIL inject_done: got seen=%0d writes=%0d required 1 34",
                     seen, wr_data.size());
        else n_pass++;
        n_checks++;
        if (wr_data[7] !== 8'h04)
            $display("FAIL inject_byte5: got %h required 04", wr_data[7]);
        else n_pass++;
        n_checks++;
        if (wr_data[8] !== 8'h7D || wr_data[33] !== 8'h39)
            $display("FAIL inject_after: got %h %h required 7d 39", wr_data[8], wr_data[33]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort_strobe();
        int n = 0;
        int done_seen = 0;
        clear_mon();
        pulse_start();
        while (!(write_idx === 6'd10 && isa_iow_n_o === 1'b0) && n < 500) begin
            @(negedge clk); n++;
        end
        n_checks++;
        if (n >= 500) $display("FAIL abort_reach_w10: got timeout required strobe of write 10");
        else n_pass++;
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_checks++;
        if (isa_iow_n_o !== 1'b1)
            $display("FAIL abort_iow_rise: got iow=%b required 1", isa_iow_n_o);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({aborted, done, isa_data_oe, bus_req, busy} !== 5'b10000)
            $display("FAIL abort_release: got aborted/done/oe/req/busy=%b%b%b%b%b required 10000",
                     aborted, done, isa_data_oe, bus_req, busy);
        else n_pass++;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        n_checks++;
        if (wr_data.size() !== 11 || done_seen !== 0)
            $display("FAIL abort_no_more: got writes=%0d done=%0d required 11 0",
                     wr_data.size(), done_seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back_gnt_delay();
        int viol = 0;
        int err = 0;
        bit seen;
        clear_mon();
        bus_gnt = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) start = 1'b1;
            if (i == 11) start = 1'b0;
            if (bus_req !== 1'b1 || isa_data_oe !== 1'b0 || isa_iow_n_o !== 1'b1) viol++;
        end
        n_checks++;
        if (viol !== 0 || wr_data.size() !== 0 || busy !== 1'b1)
            $display("FAIL gnt_wait: got viol=%0d writes=%0d busy=%b required 0 0 1",
                     viol, wr_data.size(), busy);
        else n_pass++;
        bus_gnt = 1'b1;
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(seen);
        for (int i = 0; i < 34 && i < wr_data.size(); i++)
            if (wr_data[i] !== exp_byte(i)) err++;
        n_checks++;
        if (!seen || wr_data.size() !== 34 || err !== 0)
            $display("FAIL gnt_late_seq: got seen=%0d writes=%0d bad=%0d required 1 34 0",
                     seen, wr_data.size(), err);
        else n_pass++;
        repeat (30) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || wr_data.size() !== 34)
            $display("FAIL busy_start_ignored: got busy=%b writes=%0d required 0 34",
                     busy, wr_data.size());
        else n_pass++;
    endtask

    task automatic test_gnt_drop();
        int n = 0;
        bit seen;
        clear_mon();
        pulse_start();
        while (!(write_idx === 6'd20 && isa_iow_n_o === 1'b0) && n < 600) begin
            @(negedge clk); n++;
        end
        while (isa_iow_n_o !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 600) $display("FAIL drop_reach_w20: got timeout required recover of write 20");
        else n_pass++;
        bus_gnt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (isa_iow_n_o !== 1'b1 || isa_data_o !== exp_byte(20))
            $display("FAIL drop_hold: got iow=%b data=%h required 1 %h",
                     isa_iow_n_o, isa_data_o, exp_byte(20));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({aborted, done, bus_req, isa_data_oe} !== 4'b1000)
            $display("FAIL drop_abort: got aborted/done/req/oe=%b%b%b%b required 1000",
                     aborted, done, bus_req, isa_data_oe);
        else n_pass++;
        bus_gnt = 1'b1;
        clear_mon();
        pulse_start();
        wait_done(seen);
        n_checks++;
        if (!seen || wr_data.size() !== 34 || wr_data[0] !== 8'h00 || wr_data[1] !== 8'h00 ||
            wr_data[2] !== 8'h6A)
            $display("FAIL drop_restart: got seen=%0d writes=%0d first=%h %h %h required 00 00 6a",
                     seen, wr_data.size(), wr_data[0], wr_data[1], wr_data[2]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int pulses = 0;
        int err = 0;
        bit seen;
        clear_mon();
        pulse_start();
        while (!(write_idx === 6'd3 && isa_iow_n_o === 1'b0) && n < 200) begin
            @(negedge clk); n++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({isa_iow_n_o, isa_data_oe, bus_req, busy, write_idx, isa_data_o} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00} || n >= 200)
            $display("FAIL reset_mid: got iow/oe/req/busy=%b%b%b%b idx=%0d data=%h required 1000",
                     isa_iow_n_o, isa_data_oe, bus_req, busy, write_idx, isa_data_o);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1 || aborted === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL reset_no_pulse: got %0d pulses required 0", pulses);
        else n_pass++;
        clear_mon();
        pulse_start();
        wait_done(seen);
        for (int i = 0; i < 34 && i < wr_data.size(); i++)
            if (wr_data[i] !== exp_byte(i) || wr_width[i] !== 8) err++;
        n_checks++;
        if (!seen || wr_data.size() !== 34 || err !== 0 || glitch !== 0)
            $display("FAIL reset_clean_seq: got seen=%0d writes=%0d bad=%0d glitch=%0d",
                     seen, wr_data.size(), err, glitch);
        else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_abort_req();
        test_full_sequence();
        test_inject();
        test_abort_strobe();
        test_back_to_back_gnt_delay();
        test_gnt_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
